// File: rtl/ddr_loop_pkg.sv
// Shared types and helpers for the DDR loopback sequencer.
package ddr_loop_pkg;

  localparam int unsigned STATE_W = 3;

  // State encoding; the numeric values are visible on err_state.
  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    RD_REQ     = 3'd1,
    RD_WAIT_HI = 3'd2,
    RD_WAIT_LO = 3'd3,
    WR_REQ     = 3'd4,
    WR_WAIT_HI = 3'd5,
    WR_WAIT_LO = 3'd6,
    FIN        = 3'd7
  } loop_state_e;

  // log2 of the beat size in bytes; the data width is a power-of-two multiple of 8.
  function automatic int unsigned beat_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/ddr_loop_ctrl_if.sv
// cDMA request/status bundle between the sequencer and the loopback datapath.
interface ddr_loop_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned SIZE_W = 16
) ();

  logic [ADDR_W-1:0] cdma_raddr;
  logic              cdma_raddr_vld;
  logic [SIZE_W-1:0] cdma_rsize;
  logic              cdma_rbusy;
  logic [ADDR_W-1:0] cdma_waddr;
  logic              cdma_waddr_vld;
  logic [SIZE_W-1:0] cdma_wsize;
  logic              cdma_wbusy;

  modport master (
    output cdma_raddr, cdma_raddr_vld, cdma_rsize,
    output cdma_waddr, cdma_waddr_vld, cdma_wsize,
    input  cdma_rbusy, cdma_wbusy
  );

  modport slave (
    input  cdma_raddr, cdma_raddr_vld, cdma_rsize,
    input  cdma_waddr, cdma_waddr_vld, cdma_wsize,
    output cdma_rbusy, cdma_wbusy
  );

endinterface

// File: rtl/ddr_loop_ctrl_watchdog.sv
// Saturating wait-cycle counter with synchronous clear and terminal-count flag.
module loop_watchdog #(
  parameter int unsigned LIMIT = 32'h100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  assign expired_c = (cnt == CNT_W'(LIMIT));

  // Count enabled cycles, hold at the limit, restart on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ddr_loop_ctrl.sv
// Chunked DDR->BRAM->DDR copy sequencer driving the loopback cDMA ports.
module ddr_loop_ctrl
  import ddr_loop_pkg::*;
#(
  parameter int unsigned M_AXI_ADDR_WIDTH = 16,
  parameter int unsigned M_AXI_DATA_WIDTH = 128,
  parameter int unsigned cDMA_TRANS_WIDTH = 16,
  parameter int unsigned BRAM_MEM_DEPTH   = 32'h4000,
  parameter int unsigned TOTAL_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES   = 32'h100000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [M_AXI_ADDR_WIDTH-1:0] src_addr,
  input  logic [M_AXI_ADDR_WIDTH-1:0] dst_addr,
  input  logic [TOTAL_WIDTH-1:0]      total_beats,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [STATE_W-1:0]          err_state,
  output logic [TOTAL_WIDTH-1:0]      chunk_cnt,
  ddr_loop_ctrl_if.master             cdma
);

  localparam int unsigned AW    = M_AXI_ADDR_WIDTH;
  localparam int unsigned TW    = TOTAL_WIDTH;
  localparam int unsigned SW    = cDMA_TRANS_WIDTH;
  localparam int unsigned SHIFT = beat_shift(M_AXI_DATA_WIDTH);

  // A chunk must be expressible on the size outputs.
  if (64'(BRAM_MEM_DEPTH) >= (64'd1 << SW)) begin : g_depth_chk
    $error("BRAM_MEM_DEPTH must be below 2**cDMA_TRANS_WIDTH");
  end

  loop_state_e   state, state_next;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [TW-1:0] remaining, chunk, rem_left_c;
  logic          timeout_c, chunk_end_c, wd_expired_c, wd_en_c, wd_clr_c;
  logic          rvld_d, wvld_d, busy_d, done_d;
  logic          rvld, wvld;

  function automatic logic [TW-1:0] clip_chunk(input logic [TW-1:0] beats);
    return (beats > TW'(BRAM_MEM_DEPTH)) ? TW'(BRAM_MEM_DEPTH) : beats;
  endfunction

  assign rem_left_c = remaining - chunk;
  assign wd_en_c    = (state == RD_WAIT_HI) || (state == RD_WAIT_LO) ||
                      (state == WR_WAIT_HI) || (state == WR_WAIT_LO);
  assign wd_clr_c   = (state_next != state);

  loop_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .expired_c (wd_expired_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a satisfied wait condition wins over a same-cycle timeout.
  always_comb begin
    state_next  = state;
    timeout_c   = 1'b0;
    chunk_end_c = 1'b0;
    case (state)
      IDLE:       if (start) state_next = (total_beats == '0) ? FIN : RD_REQ;
      RD_REQ:     state_next = RD_WAIT_HI;
      RD_WAIT_HI: begin
        if (cdma.cdma_rbusy)   state_next = RD_WAIT_LO;
        else if (wd_expired_c) begin timeout_c = 1'b1; state_next = FIN; end
      end
      RD_WAIT_LO: begin
        if (!cdma.cdma_rbusy)  state_next = WR_REQ;
        else if (wd_expired_c) begin timeout_c = 1'b1; state_next = FIN; end
      end
      WR_REQ:     state_next = WR_WAIT_HI;
      WR_WAIT_HI: begin
        if (cdma.cdma_wbusy)   state_next = WR_WAIT_LO;
        else if (wd_expired_c) begin timeout_c = 1'b1; state_next = FIN; end
      end
      WR_WAIT_LO: begin
        if (!cdma.cdma_wbusy) begin
          chunk_end_c = 1'b1;
          state_next  = (rem_left_c != '0) ? RD_REQ : FIN;
        end else if (wd_expired_c) begin
          timeout_c  = 1'b1;
          state_next = FIN;
        end
      end
      FIN:        state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    rvld_d = 1'b0;
    wvld_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    rvld_d = (state_next == RD_REQ);
    wvld_d = (state_next == WR_REQ);
    busy_d = (state_next != IDLE);
    done_d = (state_next == FIN);
  end

  // Registered status and request strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvld <= 1'b0;
      wvld <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      rvld <= rvld_d;
      wvld <= wvld_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Job working registers: latch on start, advance at each chunk end, record timeouts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      remaining <= '0;
      chunk     <= '0;
      chunk_cnt <= '0;
      error     <= 1'b0;
      err_state <= '0;
    end else begin
      if (state == IDLE && start) begin
        rd_ptr    <= src_addr;
        wr_ptr    <= dst_addr;
        remaining <= total_beats;
        chunk     <= clip_chunk(total_beats);
        chunk_cnt <= '0;
        error     <= 1'b0;
      end
      if (chunk_end_c) begin
        rd_ptr    <= rd_ptr + (AW'(chunk) << SHIFT);
        wr_ptr    <= wr_ptr + (AW'(chunk) << SHIFT);
        remaining <= rem_left_c;
        chunk     <= clip_chunk(rem_left_c);
        chunk_cnt <= chunk_cnt + TW'(1);
      end
      if (timeout_c) begin
        error     <= 1'b1;
        err_state <= state;
      end
    end
  end

  assign cdma.cdma_raddr     = rd_ptr;
  assign cdma.cdma_raddr_vld = rvld;
  assign cdma.cdma_rsize     = SW'(chunk);
  assign cdma.cdma_waddr     = wr_ptr;
  assign cdma.cdma_waddr_vld = wvld;
  assign cdma.cdma_wsize     = SW'(chunk);

endmodule

// File: tb/tb_ddr_loop_ctrl.sv
// Directed-vector bench for the DDR loopback sequencer with a simple cDMA responder.
module tb_ddr_loop_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [31:0] total_beats = '0;
  logic        busy, done, error;
  logic [2:0]  err_state;
  logic [31:0] chunk_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ddr_loop_ctrl_if #(.ADDR_W(16), .SIZE_W(16)) cdma ();

  ddr_loop_ctrl #(
    .M_AXI_ADDR_WIDTH(16), .M_AXI_DATA_WIDTH(128), .cDMA_TRANS_WIDTH(16),
    .BRAM_MEM_DEPTH(16), .TOTAL_WIDTH(32), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .total_beats(total_beats), .busy(busy), .done(done), .error(error),
    .err_state(err_state), .chunk_cnt(chunk_cnt), .cdma(cdma)
  );

  always #5 clk = ~clk;

  // cDMA responder: busy rises 2 cycles after a request and stays high size+4 cycles.
  logic rbusy_m = 1'b0, wbusy_m = 1'b0, wbusy_en = 1'b1;
  int   rdly = 0, wdly = 0, rhold = 0, whold = 0, rlen = 0, wlen = 0;

  typedef struct packed { logic [15:0] addr; logic [15:0] size; } ev_t;
  ev_t rq[$];
  ev_t wq[$];

  assign cdma.cdma_rbusy = rbusy_m;
  assign cdma.cdma_wbusy = wbusy_m;

  always @(negedge clk) begin
    ev_t ev;
    if (!rst_n) begin
      rbusy_m = 1'b0; wbusy_m = 1'b0; rdly = 0; wdly = 0; rhold = 0; whold = 0;
    end else begin
      if (rbusy_m) begin
        if (rhold <= 1) rbusy_m = 1'b0; else rhold--;
      end else if (rdly > 0) begin
        rdly--;
        if (rdly == 0) begin rbusy_m = 1'b1; rhold = rlen; end
      end
      if (wbusy_m) begin
        if (whold <= 1) wbusy_m = 1'b0; else whold--;
      end else if (wdly > 0) begin
        wdly--;
        if (wdly == 0 && wbusy_en) begin wbusy_m = 1'b1; whold = wlen; end
      end
      if (cdma.cdma_raddr_vld) begin
        rdly = 2; rlen = int'(cdma.cdma_rsize) + 4;
        ev.addr = cdma.cdma_raddr; ev.size = cdma.cdma_rsize; rq.push_back(ev);
      end
      if (cdma.cdma_waddr_vld) begin
        wdly = 2; wlen = int'(cdma.cdma_wsize) + 4;
        ev.addr = cdma.cdma_waddr; ev.size = cdma.cdma_wsize; wq.push_back(ev);
      end
    end
  end

  typedef struct packed {
    logic [15:0]      src;
    logic [15:0]      dst;
    logic [31:0]      total;
    logic [31:0]      chunks;
    logic [2:0][15:0] ra;
    logic [2:0][15:0] wa;
    logic [2:0][15:0] sz;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [15:0] s, d, input logic [31:0] t, c,
                              input logic [15:0] r0, r1, r2, w0, w1, w2, s0, s1, s2);
    vec_t v;
    v.src = s; v.dst = d; v.total = t; v.chunks = c;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2;
    v.wa[0] = w0; v.wa[1] = w1; v.wa[2] = w2;
    v.sz[0] = s0; v.sz[1] = s1; v.sz[2] = s2;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},      64'(busy), 64'(0));
    check({tag, ".done"},      64'(done), 64'(0));
    check({tag, ".error"},     64'(error), 64'(0));
    check({tag, ".err_state"}, 64'(err_state), 64'(0));
    check({tag, ".chunk_cnt"}, 64'(chunk_cnt), 64'(0));
    check({tag, ".raddr"},     64'(cdma.cdma_raddr), 64'(0));
    check({tag, ".rvld"},      64'(cdma.cdma_raddr_vld), 64'(0));
    check({tag, ".rsize"},     64'(cdma.cdma_rsize), 64'(0));
    check({tag, ".waddr"},     64'(cdma.cdma_waddr), 64'(0));
    check({tag, ".wvld"},      64'(cdma.cdma_waddr_vld), 64'(0));
    check({tag, ".wsize"},     64'(cdma.cdma_wsize), 64'(0));
  endtask

  task automatic pulse_start(input logic [15:0] s, d, input logic [31:0] t);
    @(negedge clk);
    src_addr = s; dst_addr = d; total_beats = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, ".done_seen"}, 64'(got), 64'(1));
  endtask

  // One full job from a table row, checked cycle 1, completion and the request log.
  task automatic run_job(input vec_t v, input string tag);
    rq.delete(); wq.delete();
    pulse_start(v.src, v.dst, v.total);
    check({tag, ".busy_c1"},  64'(busy), 64'(1));
    check({tag, ".rvld_c1"},  64'(cdma.cdma_raddr_vld), 64'(v.total != 0));
    check({tag, ".done_c1"},  64'(done), 64'(v.total == 0));
    check({tag, ".error_c1"}, 64'(error), 64'(0));
    wait_done(3000, tag);
    check({tag, ".chunk_cnt"}, 64'(chunk_cnt), 64'(v.chunks));
    check({tag, ".error"},     64'(error), 64'(0));
    @(negedge clk);
    check({tag, ".done_after"}, 64'(done), 64'(0));
    check({tag, ".busy_after"}, 64'(busy), 64'(0));
    check({tag, ".n_rd"}, 64'(rq.size()), 64'(v.chunks));
    check({tag, ".n_wr"}, 64'(wq.size()), 64'(v.chunks));
    for (int i = 0; i < int'(v.chunks); i++) begin
      if (i < rq.size()) begin
        check($sformatf("%s.raddr%0d", tag, i), 64'(rq[i].addr), 64'(v.ra[i]));
        check($sformatf("%s.rsize%0d", tag, i), 64'(rq[i].size), 64'(v.sz[i]));
      end
      if (i < wq.size()) begin
        check($sformatf("%s.waddr%0d", tag, i), 64'(wq[i].addr), 64'(v.wa[i]));
        check($sformatf("%s.wsize%0d", tag, i), 64'(wq[i].size), 64'(v.sz[i]));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vecs[0] = mk(16'h0100, 16'h2000, 10, 1, 16'h0100, 16'h0, 16'h0,
                 16'h2000, 16'h0, 16'h0, 16'd10, 16'd0, 16'd0);
    vecs[1] = mk(16'h0000, 16'h8000, 37, 3, 16'h0000, 16'h0100, 16'h0200,
                 16'h8000, 16'h8100, 16'h8200, 16'd16, 16'd16, 16'd5);
    vecs[2] = mk(16'h0000, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h0,
                 16'h0, 16'h0, 16'h0, 16'd0, 16'd0, 16'd0);
    vecs[3] = mk(16'hFF80, 16'h1000, 32, 2, 16'hFF80, 16'h0080, 16'h0,
                 16'h1000, 16'h1100, 16'h0, 16'd16, 16'd16, 16'd0);
    vecs[4] = mk(16'h0040, 16'h0400, 16, 1, 16'h0040, 16'h0, 16'h0,
                 16'h0400, 16'h0, 16'h0, 16'd16, 16'd0, 16'd0);
    vecs[5] = mk(16'h0010, 16'h3000, 17, 2, 16'h0010, 16'h0110, 16'h0,
                 16'h3000, 16'h3100, 16'h0, 16'd16, 16'd1, 16'd0);

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Write side never answers: watchdog fires in WR_WAIT_HI and still ends the job.
    wbusy_en = 1'b0;
    rq.delete(); wq.delete();
    pulse_start(16'h0100, 16'h2000, 10);
    wait_done(500, "tmo");
    check("tmo.error",     64'(error), 64'(1));
    check("tmo.err_state", 64'(err_state), 64'(5));
    check("tmo.chunk_cnt", 64'(chunk_cnt), 64'(0));
    check("tmo.n_rd",      64'(rq.size()), 64'(1));
    check("tmo.n_wr",      64'(wq.size()), 64'(1));
    @(negedge clk);
    check("tmo.done_after",   64'(done), 64'(0));
    check("tmo.error_sticky", 64'(error), 64'(1));
    wbusy_en = 1'b1;
    run_job(vecs[0], "after_tmo");

    // Start while busy is ignored; reset in RD_WAIT_LO clears everything.
    rq.delete(); wq.delete();
    pulse_start(16'h0000, 16'h8000, 37);
    pulse_start(16'h4000, 16'h5000, 5);
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (rbusy_m) begin seen = 1'b1; break; end
      end
      check("rst.rbusy_seen", 64'(seen), 64'(1));
    end
    @(negedge clk);
    check("rst.busy_before",  64'(busy), 64'(1));
    check("rst.n_rd_before",  64'(rq.size()), 64'(1));
    check("rst.raddr_before", 64'(cdma.cdma_raddr), 64'(16'h0000));
    check("rst.rsize_before", 64'(cdma.cdma_rsize), 64'(16));
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rq.delete(); wq.delete();
    repeat (40) @(negedge clk);
    check("rst.n_rd_after", 64'(rq.size()), 64'(0));
    check("rst.n_wr_after", 64'(wq.size()), 64'(0));
    check_all_zero("rst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
